// File: rtl/serv_pc_bank.sv
// Bit-serial next-PC unit with per-hart PC banks. Digits are produced LSB first and the
// assembled PC commits to its bank only after the final digit, so o_ibus_adr is stable mid-pass.
//
// state   | meaning
// S_IDLE  | waiting for i_start; o_ibus_adr shows the committed PC of o_hart
// S_SHIFT | one digit per cycle, cnt = 0 .. 32/W-1
module serv_pc_bank #(
  parameter int          W               = 1,
  parameter int          NHART           = 1,
  parameter logic [31:0] RESET_PC        = 32'd0,
  parameter bit          WITH_CSR        = 1'b1,
  parameter bit          WITH_COMPRESSED = 1'b0,
  localparam int         HW              = (NHART > 1) ? $clog2(NHART) : 1
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [HW-1:0] i_hart,
  input  logic          i_jump,
  input  logic          i_jal_or_jalr,
  input  logic          i_utype,
  input  logic          i_pc_rel,
  input  logic          i_trap,
  input  logic          i_iscomp,
  input  logic [W-1:0]  i_imm,
  input  logic [W-1:0]  i_buf,
  input  logic [W-1:0]  i_csr_pc,
  output logic [W-1:0]  o_rd,
  output logic [W-1:0]  o_bad_pc,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_misalign,
  output logic [HW-1:0] o_hart,
  output logic [31:0]   o_ibus_adr
);

  localparam int            NPASS = 32 / W;
  localparam int            CW    = $clog2(NPASS);
  localparam logic [CW-1:0] LAST  = CW'(NPASS - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             c4_r, co_r, mis_acc;
  logic [31-W:0]    shadow;
  logic [31:0]      bank [NHART];

  logic [W-1:0]     pc_d, plus4_d, off_d, pc_rel_d, trap_d, tgt_d, nxt_d;
  logic [W:0]       sum4, sumo;
  logic [4:0]       inc_bit;
  logic             tgt_b1, trap_en, mis_now;
  logic [HW-1:0]    hart_sel;

  function automatic logic [4:0] bit_pos(input logic [CW-1:0] c, input int j);
    return 5'(int'(c) * W + j);
  endfunction

  assign o_ibus_adr = bank[o_hart];

  always_comb begin
    inc_bit  = (WITH_COMPRESSED && i_iscomp) ? 5'd1 : 5'd2;
    pc_d     = '0;
    plus4_d  = '0;
    off_d    = '0;
    trap_d   = '0;
    for (int j = 0; j < W; j++) begin
      pc_d[j]    = o_ibus_adr[bit_pos(cnt, j)];
      plus4_d[j] = (bit_pos(cnt, j) == inc_bit);
      // LUI/AUIPC immediates only contribute from bit 12 upward
      off_d[j]   = i_utype ? ((bit_pos(cnt, j) >= 5'd12) && i_imm[j]) : i_buf[j];
      trap_d[j]  = (bit_pos(cnt, j) >= 5'd2) && i_csr_pc[j];
    end
    pc_rel_d = i_pc_rel ? pc_d : '0;
    sum4     = {1'b0, pc_d} + {1'b0, plus4_d} + {{W{1'b0}}, c4_r};
    sumo     = {1'b0, pc_rel_d} + {1'b0, off_d} + {{W{1'b0}}, co_r};
    tgt_d    = sumo[W-1:0];
    tgt_b1   = 1'b0;
    for (int j = 0; j < W; j++) begin
      if (bit_pos(cnt, j) == 5'd0) tgt_d[j] = 1'b0;
      if (bit_pos(cnt, j) == 5'd1) tgt_b1 = sumo[j];
    end
    trap_en  = WITH_CSR && i_trap;
    nxt_d    = trap_en ? trap_d : (i_jump ? tgt_d : sum4[W-1:0]);
    mis_now  = i_jump && !trap_en && tgt_b1 && !WITH_COMPRESSED;
    o_bad_pc = tgt_d;
    o_rd     = (i_utype ? tgt_d : '0) | (i_jal_or_jalr ? sum4[W-1:0] : '0);
    hart_sel = (int'(i_hart) >= NHART) ? HW'(NHART - 1) : i_hart;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      c4_r       <= 1'b0;
      co_r       <= 1'b0;
      mis_acc    <= 1'b0;
      shadow     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_misalign <= 1'b0;
      o_hart     <= '0;
      for (int h = 0; h < NHART; h++) bank[h] <= RESET_PC;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state      <= S_SHIFT;
            o_busy     <= 1'b1;
            o_hart     <= hart_sel;
            cnt        <= '0;
            c4_r       <= 1'b0;
            co_r       <= 1'b0;
            mis_acc    <= 1'b0;
            o_misalign <= 1'b0;
          end
        end
        S_SHIFT: begin
          c4_r    <= sum4[W];
          co_r    <= sumo[W];
          mis_acc <= mis_acc | mis_now;
          cnt     <= cnt + 1'b1;
          if (cnt != LAST) begin
            for (int j = 0; j < W; j++) shadow[bit_pos(cnt, j)] <= nxt_d[j];
          end else begin
            // final digit goes straight into the bank; a misaligned jump leaves it untouched
            state      <= S_IDLE;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            o_misalign <= mis_acc | mis_now;
            if (!(mis_acc | mis_now)) bank[o_hart] <= {nxt_d, shadow};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_pc_bank.sv
// Bench for serv_pc_bank: four configurations (W = 1,2,4,8) checked against a word-level
// model of the next-PC rules, using a directed table, hand sequences and random passes.
module tb_serv_pc_bank;

  localparam int          WT   [4] = '{1, 2, 4, 8};
  localparam int          NHT  [4] = '{1, 4, 3, 2};
  localparam int          HWT  [4] = '{1, 2, 2, 1};
  localparam logic [31:0] RSTT [4] = '{32'h0, 32'h100, 32'h100, 32'hFFFF_FFFC};
  localparam bit          CSRT [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam bit          COMPT[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  typedef struct {
    int          dut;
    int          hart;
    bit          jump, jal, utype, pcrel, trap, iscomp;
    logic [31:0] imm, bufv, csr;
    logic [31:0] exp_pc;
    bit          exp_mis;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [1:0]  hart;
  logic        jump, jal, utype, pcrel, trap, iscomp;
  logic [31:0] imm32, buf32, csr32;
  int          dig;
  int          sel;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] bank_m [4][4];

  always #5 clk = ~clk;

  logic       d0_imm, d0_buf, d0_csr, d0_rd, d0_bad, d0_busy, d0_done, d0_mis, d0_hart;
  logic [1:0] d1_imm, d1_buf, d1_csr, d1_rd, d1_bad, d1_hart;
  logic [3:0] d2_imm, d2_buf, d2_csr, d2_rd, d2_bad;
  logic [1:0] d2_hart;
  logic [7:0] d3_imm, d3_buf, d3_csr, d3_rd, d3_bad;
  logic       d3_hart, d1_busy, d1_done, d1_mis, d2_busy, d2_done, d2_mis, d3_busy, d3_done, d3_mis;
  logic [31:0] d0_adr, d1_adr, d2_adr, d3_adr;

  assign d0_imm = 1'(imm32 >> dig);     assign d0_buf = 1'(buf32 >> dig);     assign d0_csr = 1'(csr32 >> dig);
  assign d1_imm = 2'(imm32 >> (2*dig)); assign d1_buf = 2'(buf32 >> (2*dig)); assign d1_csr = 2'(csr32 >> (2*dig));
  assign d2_imm = 4'(imm32 >> (4*dig)); assign d2_buf = 4'(buf32 >> (4*dig)); assign d2_csr = 4'(csr32 >> (4*dig));
  assign d3_imm = 8'(imm32 >> (8*dig)); assign d3_buf = 8'(buf32 >> (8*dig)); assign d3_csr = 8'(csr32 >> (8*dig));

  serv_pc_bank #(.W(1), .NHART(1), .RESET_PC(32'h0), .WITH_CSR(1'b1), .WITH_COMPRESSED(1'b0)) u_d0 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start_v[0]), .i_hart(hart[0]), .i_jump(jump),
    .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pcrel), .i_trap(trap), .i_iscomp(iscomp),
    .i_imm(d0_imm), .i_buf(d0_buf), .i_csr_pc(d0_csr), .o_rd(d0_rd), .o_bad_pc(d0_bad),
    .o_busy(d0_busy), .o_done(d0_done), .o_misalign(d0_mis), .o_hart(d0_hart), .o_ibus_adr(d0_adr));

  serv_pc_bank #(.W(2), .NHART(4), .RESET_PC(32'h100), .WITH_CSR(1'b1), .WITH_COMPRESSED(1'b0)) u_d1 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start_v[1]), .i_hart(hart), .i_jump(jump),
    .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pcrel), .i_trap(trap), .i_iscomp(iscomp),
    .i_imm(d1_imm), .i_buf(d1_buf), .i_csr_pc(d1_csr), .o_rd(d1_rd), .o_bad_pc(d1_bad),
    .o_busy(d1_busy), .o_done(d1_done), .o_misalign(d1_mis), .o_hart(d1_hart), .o_ibus_adr(d1_adr));

  serv_pc_bank #(.W(4), .NHART(3), .RESET_PC(32'h100), .WITH_CSR(1'b0), .WITH_COMPRESSED(1'b1)) u_d2 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start_v[2]), .i_hart(hart), .i_jump(jump),
    .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pcrel), .i_trap(trap), .i_iscomp(iscomp),
    .i_imm(d2_imm), .i_buf(d2_buf), .i_csr_pc(d2_csr), .o_rd(d2_rd), .o_bad_pc(d2_bad),
    .o_busy(d2_busy), .o_done(d2_done), .o_misalign(d2_mis), .o_hart(d2_hart), .o_ibus_adr(d2_adr));

  serv_pc_bank #(.W(8), .NHART(2), .RESET_PC(32'hFFFF_FFFC), .WITH_CSR(1'b1), .WITH_COMPRESSED(1'b1)) u_d3 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start_v[3]), .i_hart(hart[0]), .i_jump(jump),
    .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pcrel), .i_trap(trap), .i_iscomp(iscomp),
    .i_imm(d3_imm), .i_buf(d3_buf), .i_csr_pc(d3_csr), .o_rd(d3_rd), .o_bad_pc(d3_bad),
    .o_busy(d3_busy), .o_done(d3_done), .o_misalign(d3_mis), .o_hart(d3_hart), .o_ibus_adr(d3_adr));

  logic [7:0]  s_rd, s_bad;
  logic        s_busy, s_done, s_mis;
  logic [1:0]  s_hart;
  logic [31:0] s_adr;

  always_comb begin
    s_rd = '0; s_bad = '0; s_busy = 1'b0; s_done = 1'b0; s_mis = 1'b0; s_hart = '0; s_adr = '0;
    case (sel)
      0: begin s_rd = 8'(d0_rd); s_bad = 8'(d0_bad); s_busy = d0_busy; s_done = d0_done;
               s_mis = d0_mis; s_hart = 2'(d0_hart); s_adr = d0_adr; end
      1: begin s_rd = 8'(d1_rd); s_bad = 8'(d1_bad); s_busy = d1_busy; s_done = d1_done;
               s_mis = d1_mis; s_hart = d1_hart; s_adr = d1_adr; end
      2: begin s_rd = 8'(d2_rd); s_bad = 8'(d2_bad); s_busy = d2_busy; s_done = d2_done;
               s_mis = d2_mis; s_hart = d2_hart; s_adr = d2_adr; end
      default: begin s_rd = d3_rd; s_bad = d3_bad; s_busy = d3_busy; s_done = d3_done;
               s_mis = d3_mis; s_hart = 2'(d3_hart); s_adr = d3_adr; end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d): got %h expected %h at %0t", name, sel, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++)
      for (int h = 0; h < 4; h++) bank_m[d][h] = RSTT[d];
  endtask

  // One full pass; the model works on whole 32-bit words, the DUT one digit at a time.
  task automatic run_pass(input vec_t v, input bit use_exp, input bit b2b, input bit poke);
    int d, n, hm, eh;
    logic [31:0] pc, off, tgt, pc4, nxt, rd, exp_pc, rd_acc, bad_acc;
    bit trap_eff, mis;
    d        = v.dut;
    n        = 32 / WT[d];
    hm       = v.hart & ((1 << HWT[d]) - 1);
    eh       = (hm >= NHT[d]) ? NHT[d] - 1 : hm;
    pc       = bank_m[d][eh];
    off      = v.utype ? (v.imm & 32'hFFFF_F000) : v.bufv;
    tgt      = ((v.pcrel ? pc : 32'd0) + off) & ~32'd1;
    pc4      = pc + ((COMPT[d] && v.iscomp) ? 32'd2 : 32'd4);
    trap_eff = v.trap && CSRT[d];
    nxt      = trap_eff ? (v.csr & ~32'd3) : (v.jump ? tgt : pc4);
    mis      = v.jump && !trap_eff && tgt[1] && !COMPT[d];
    rd       = (v.utype ? tgt : 32'd0) | (v.jal ? pc4 : 32'd0);
    exp_pc   = mis ? pc : nxt;

    if (!b2b) @(negedge clk);
    sel = d; hart = 2'(v.hart); jump = v.jump; jal = v.jal; utype = v.utype;
    pcrel = v.pcrel; trap = v.trap; iscomp = v.iscomp;
    imm32 = v.imm; buf32 = v.bufv; csr32 = v.csr; dig = 0;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    chk("busy_at_start", 32'(s_busy), 32'd1);
    chk("done_low_at_start", 32'(s_done), 32'd0);
    chk("pc_at_start", s_adr, pc);
    chk("hart_at_start", 32'(s_hart), 32'(eh));
    rd_acc = '0; bad_acc = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rd_acc  |= 32'(s_rd) << (k * WT[d]);
      bad_acc |= 32'(s_bad) << (k * WT[d]);
      if (poke && k == 2) begin
        start_v[d] = 1'b1;
        hart = 2'(v.hart + 1);
      end
      @(posedge clk); #1;
      start_v = '0;
      dig = k + 1;
    end
    @(negedge clk);
    chk("done_pulse", 32'(s_done), 32'd1);
    chk("busy_end", 32'(s_busy), 32'd0);
    chk("misalign", 32'(s_mis), 32'(mis));
    chk("pc_commit", s_adr, exp_pc);
    chk("rd_stream", rd_acc, rd);
    chk("bad_pc_stream", bad_acc, tgt);
    chk("hart_held", 32'(s_hart), 32'(eh));
    if (use_exp) begin
      chk("tbl_pc", s_adr, v.exp_pc);
      chk("tbl_mis", 32'(s_mis), 32'(v.exp_mis));
      chk("tbl_rd", rd_acc, v.exp_rd);
    end
    if (!mis) bank_m[d][eh] = nxt;
  endtask

  vec_t tbl [17];
  vec_t rv;

  initial begin
    //        dut hart jmp jal ut rel trp cmp  imm           buf        csr           exp_pc        mis  exp_rd
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,        32'h4,        1'b0, 32'h0};
    tbl[1]  = '{0, 0, 1, 1, 0, 1, 0, 0, 32'h0,        32'h20,   32'h0,        32'h24,       1'b0, 32'h8};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,    32'h8000_0007, 32'h8000_0004, 1'b0, 32'h0};
    tbl[3]  = '{0, 0, 1, 0, 0, 1, 0, 0, 32'h0,        32'h6,    32'h0,        32'h8000_0004, 1'b1, 32'h0};
    tbl[4]  = '{1, 2, 1, 0, 0, 1, 0, 0, 32'h0,        32'h2,    32'h0,        32'h100,      1'b1, 32'h0};
    tbl[5]  = '{1, 2, 1, 1, 0, 1, 0, 0, 32'h0,        32'h20,   32'h0,        32'h120,      1'b0, 32'h104};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,        32'h104,      1'b0, 32'h0};
    tbl[7]  = '{1, 2, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,        32'h124,      1'b0, 32'h0};
    tbl[8]  = '{1, 1, 0, 0, 1, 1, 0, 0, 32'h1234_5678, 32'h0,   32'h0,        32'h104,      1'b0, 32'h1234_5100};
    tbl[9]  = '{1, 3, 1, 1, 0, 0, 0, 0, 32'h0,        32'h1235, 32'h0,        32'h1234,     1'b0, 32'h104};
    tbl[10] = '{2, 0, 1, 1, 0, 1, 0, 0, 32'h0,        32'h20,   32'h0,        32'h120,      1'b0, 32'h104};
    tbl[11] = '{2, 1, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,    32'h8000_0007, 32'h104,      1'b0, 32'h0};
    tbl[12] = '{2, 3, 0, 1, 0, 0, 0, 1, 32'h0,        32'h0,    32'h0,        32'h102,      1'b0, 32'h102};
    tbl[13] = '{2, 2, 1, 0, 0, 1, 0, 1, 32'h0,        32'h4,    32'h0,        32'h106,      1'b0, 32'h0};
    tbl[14] = '{3, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,        32'h0,        1'b0, 32'h0};
    tbl[15] = '{3, 1, 1, 0, 0, 0, 1, 0, 32'h0,        32'h3,    32'h8000_0007, 32'h8000_0004, 1'b0, 32'h0};
    tbl[16] = '{3, 1, 0, 0, 1, 0, 0, 1, 32'hABCD_E123, 32'h0,   32'h0,        32'h8000_0006, 1'b0, 32'hABCD_E000};

    rst_n = 1'b0; start_v = '0; hart = '0; jump = 1'b0; jal = 1'b0; utype = 1'b0;
    pcrel = 1'b0; trap = 1'b0; iscomp = 1'b0; imm32 = '0; buf32 = '0; csr32 = '0;
    dig = 0; sel = 0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      sel = d; #1;
      chk("rst_busy", 32'(s_busy), 32'd0);
      chk("rst_done", 32'(s_done), 32'd0);
      chk("rst_mis", 32'(s_mis), 32'd0);
      chk("rst_hart", 32'(s_hart), 32'd0);
      chk("rst_pc", s_adr, RSTT[d]);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) run_pass(tbl[i], 1'b1, 1'b0, 1'b0);

    // back-to-back: second start lands in the o_done cycle
    rv = '{1, 0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
    run_pass(rv, 1'b0, 1'b0, 1'b0);
    rv.hart = 3;
    run_pass(rv, 1'b0, 1'b1, 1'b0);
    // start during SHIFT with a different hart must be ignored
    rv.hart = 1;
    run_pass(rv, 1'b0, 1'b0, 1'b1);

    // reset while cnt = 5 aborts the pass without a commit
    @(negedge clk);
    sel = 1; hart = 2'd2; jump = 1'b1; pcrel = 1'b1; buf32 = 32'h40; trap = 1'b0; utype = 1'b0;
    dig = 0; start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    for (int k = 0; k < 5; k++) begin
      dig = k;
      @(posedge clk); #1;
    end
    dig = 5;
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrst_busy", 32'(s_busy), 32'd0);
    chk("midrst_done", 32'(s_done), 32'd0);
    chk("midrst_hart", 32'(s_hart), 32'd0);
    chk("midrst_pc", s_adr, 32'h100);
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(s_done), 32'd0);
    end
    rst_n = 1'b1;
    rv = '{1, 2, 1, 1, 0, 1, 0, 0, 32'h0, 32'h40, 32'h0, 32'h140, 1'b0, 32'h104};
    run_pass(rv, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 48; i++) begin
      rv.dut    = $urandom_range(0, 3);
      rv.hart   = $urandom_range(0, 3);
      rv.jump   = 1'($urandom_range(0, 1));
      rv.jal    = 1'($urandom_range(0, 1));
      rv.utype  = 1'($urandom_range(0, 1));
      rv.pcrel  = 1'($urandom_range(0, 1));
      rv.trap   = ($urandom_range(0, 3) == 0);
      rv.iscomp = 1'($urandom_range(0, 1));
      rv.imm    = $urandom;
      rv.bufv   = $urandom & (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      rv.csr    = $urandom;
      run_pass(rv, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
